// File: rtl/execute.sv
// ---------------------------------------------------------------------------
// execute -- EX stage of a 16-bit in-order pipeline plus the EX/MEM register.
//
// Computes the ALU result, the branch target and the branch decision for the
// instruction held in ID/EX, then registers them with the forwarded control
// into EX/MEM one cycle later.
//
// Ports
//   clk, rst            pipeline clock, asynchronous active-high reset
//   *_IDEX              operands and control of the instruction in EX
//   ALURes_EXMEM        ALU result / memory address
//   WrData_EXMEM        store data (register operand B)
//   BrTarget_EXMEM      PC+2 + immediate
//   takeBranch_EXMEM    branch taken (one cycle), fed back to fetch/decode
//   WrR_EXMEM, RegWrite/MemWrite/MemRead/MemtoReg/Dump/halt_EXMEM  control
//   err                 combinational: unassigned ALUOp with a write/read enable
// ---------------------------------------------------------------------------
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] PC2_IDEX,
    input  logic [15:0] Rd1_IDEX,
    input  logic [15:0] Rd2_IDEX,
    input  logic [15:0] Imm_IDEX,
    input  logic [4:0]  ALUOp_IDEX,
    input  logic [1:0]  ALUF_IDEX,
    input  logic        ALUSrc_IDEX,
    input  logic        Branch_IDEX,
    input  logic        MemtoReg_IDEX,
    input  logic        MemWrite_IDEX,
    input  logic        MemRead_IDEX,
    input  logic        RegWrite_IDEX,
    input  logic        Dump_IDEX,
    input  logic        halt_IDEX,
    input  logic [2:0]  WrR_IDEX,
    output logic [15:0] ALURes_EXMEM,
    output logic [15:0] WrData_EXMEM,
    output logic [15:0] BrTarget_EXMEM,
    output logic        takeBranch_EXMEM,
    output logic [2:0]  WrR_EXMEM,
    output logic        RegWrite_EXMEM,
    output logic        MemWrite_EXMEM,
    output logic        MemRead_EXMEM,
    output logic        MemtoReg_EXMEM,
    output logic        Dump_EXMEM,
    output logic        halt_EXMEM,
    output logic        err
);

    logic [15:0] op_a_s;
    logic [15:0] op_b_s;
    logic [3:0]  shamt_s;
    logic [16:0] sum_s;
    logic [31:0] rot_s;
    logic [15:0] alu_res_s;
    logic        cond_s;
    logic        kill_s;
    logic        take_s;

    // Operand selection and shared adder/rotator terms.
    always_comb begin
        op_a_s  = Rd1_IDEX;
        op_b_s  = ALUSrc_IDEX ? Imm_IDEX : Rd2_IDEX;
        shamt_s = op_b_s[3:0];
        sum_s   = {1'b0, op_a_s} + {1'b0, op_b_s};
        // Rotating a doubled copy left leaves the rotated word in the top half.
        rot_s   = {op_a_s, op_a_s} << shamt_s;
    end

    // ALU result by operation code; unassigned codes produce zero.
    always_comb begin
        alu_res_s = 16'h0000;
        case (ALUOp_IDEX)
            5'h00:   alu_res_s = sum_s[15:0];
            5'h01:   alu_res_s = op_b_s - op_a_s;
            5'h02:   alu_res_s = op_a_s & op_b_s;
            5'h03:   alu_res_s = op_a_s | op_b_s;
            5'h04:   alu_res_s = op_a_s ^ op_b_s;
            5'h05:   alu_res_s = op_a_s << shamt_s;
            5'h06:   alu_res_s = op_a_s >> shamt_s;
            5'h07:   alu_res_s = rot_s[31:16];
            5'h08:   alu_res_s = op_b_s;
            5'h09:   alu_res_s = (op_a_s == op_b_s) ? 16'h0001 : 16'h0000;
            5'h0A:   alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? 16'h0001 : 16'h0000;
            5'h0B:   alu_res_s = ($signed(op_a_s) <= $signed(op_b_s)) ? 16'h0001 : 16'h0000;
            5'h0C:   alu_res_s = {15'h0000, sum_s[16]};
            5'h0D:   alu_res_s = PC2_IDEX;
            default: alu_res_s = 16'h0000;
        endcase
    end

    // Branch condition evaluated on operand A.
    always_comb begin
        cond_s = 1'b0;
        case (ALUF_IDEX)
            2'b00:   cond_s = (Rd1_IDEX == 16'h0000);
            2'b01:   cond_s = (Rd1_IDEX != 16'h0000);
            2'b10:   cond_s = Rd1_IDEX[15];
            2'b11:   cond_s = ~Rd1_IDEX[15];
            default: cond_s = 1'b0;
        endcase
    end

    // An instruction behind a taken branch is wrong-path; after halt nothing
    // further may write, so both cases suppress the side-effect enables.
    always_comb begin
        kill_s = takeBranch_EXMEM | halt_EXMEM;
        take_s = Branch_IDEX & cond_s & ~kill_s;
        err    = (ALUOp_IDEX > 5'h0D) & (RegWrite_IDEX | MemWrite_IDEX | MemRead_IDEX);
    end

    // EX/MEM pipeline register, always enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALURes_EXMEM     <= 16'h0000;
            WrData_EXMEM     <= 16'h0000;
            BrTarget_EXMEM   <= 16'h0000;
            takeBranch_EXMEM <= 1'b0;
            WrR_EXMEM        <= 3'b000;
            RegWrite_EXMEM   <= 1'b0;
            MemWrite_EXMEM   <= 1'b0;
            MemRead_EXMEM    <= 1'b0;
            MemtoReg_EXMEM   <= 1'b0;
            Dump_EXMEM       <= 1'b0;
            halt_EXMEM       <= 1'b0;
        end else begin
            ALURes_EXMEM     <= alu_res_s;
            WrData_EXMEM     <= Rd2_IDEX;
            BrTarget_EXMEM   <= PC2_IDEX + Imm_IDEX;
            takeBranch_EXMEM <= take_s;
            WrR_EXMEM        <= WrR_IDEX;
            RegWrite_EXMEM   <= RegWrite_IDEX & ~kill_s;
            MemWrite_EXMEM   <= MemWrite_IDEX & ~kill_s;
            MemRead_EXMEM    <= MemRead_IDEX & ~kill_s;
            MemtoReg_EXMEM   <= MemtoReg_IDEX;
            Dump_EXMEM       <= Dump_IDEX & ~kill_s;
            // Halt is sticky; a wrong-path halt is ignored.
            halt_EXMEM       <= halt_EXMEM | (halt_IDEX & ~takeBranch_EXMEM);
        end
    end

endmodule

// File: tb/tb_execute.sv
// ---------------------------------------------------------------------------
// tb_execute -- directed self-checking bench for the execute stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled there
// too, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_execute;

    logic        clk;
    logic        rst;
    logic [15:0] PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
    logic [4:0]  ALUOp_IDEX;
    logic [1:0]  ALUF_IDEX;
    logic        ALUSrc_IDEX, Branch_IDEX, MemtoReg_IDEX, MemWrite_IDEX;
    logic        MemRead_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX;
    logic [2:0]  WrR_IDEX;
    logic [15:0] ALURes_EXMEM, WrData_EXMEM, BrTarget_EXMEM;
    logic        takeBranch_EXMEM;
    logic [2:0]  WrR_EXMEM;
    logic        RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM;
    logic        MemtoReg_EXMEM, Dump_EXMEM, halt_EXMEM, err;

    int err_cnt = 0;
    int chk_cnt = 0;

    execute dut (
        .clk(clk), .rst(rst),
        .PC2_IDEX(PC2_IDEX), .Rd1_IDEX(Rd1_IDEX), .Rd2_IDEX(Rd2_IDEX),
        .Imm_IDEX(Imm_IDEX), .ALUOp_IDEX(ALUOp_IDEX), .ALUF_IDEX(ALUF_IDEX),
        .ALUSrc_IDEX(ALUSrc_IDEX), .Branch_IDEX(Branch_IDEX),
        .MemtoReg_IDEX(MemtoReg_IDEX), .MemWrite_IDEX(MemWrite_IDEX),
        .MemRead_IDEX(MemRead_IDEX), .RegWrite_IDEX(RegWrite_IDEX),
        .Dump_IDEX(Dump_IDEX), .halt_IDEX(halt_IDEX), .WrR_IDEX(WrR_IDEX),
        .ALURes_EXMEM(ALURes_EXMEM), .WrData_EXMEM(WrData_EXMEM),
        .BrTarget_EXMEM(BrTarget_EXMEM), .takeBranch_EXMEM(takeBranch_EXMEM),
        .WrR_EXMEM(WrR_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .MemWrite_EXMEM(MemWrite_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .MemtoReg_EXMEM(MemtoReg_EXMEM), .Dump_EXMEM(Dump_EXMEM),
        .halt_EXMEM(halt_EXMEM), .err(err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        PC2_IDEX = 16'h0000; Rd1_IDEX = 16'h0000; Rd2_IDEX = 16'h0000;
        Imm_IDEX = 16'h0000; ALUOp_IDEX = 5'h00; ALUF_IDEX = 2'b00;
        ALUSrc_IDEX = 1'b0; Branch_IDEX = 1'b0; MemtoReg_IDEX = 1'b0;
        MemWrite_IDEX = 1'b0; MemRead_IDEX = 1'b0; RegWrite_IDEX = 1'b0;
        Dump_IDEX = 1'b0; halt_IDEX = 1'b0; WrR_IDEX = 3'b000;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alures"}, ALURes_EXMEM, 16'h0000);
        check({tag, "_wrdata"}, WrData_EXMEM, 16'h0000);
        check({tag, "_brtgt"}, BrTarget_EXMEM, 16'h0000);
        check({tag, "_flags"},
              16'({takeBranch_EXMEM, RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM,
                   MemtoReg_EXMEM, Dump_EXMEM, halt_EXMEM, WrR_EXMEM}),
              16'h0000);
    endtask

    // One register-register ALU op; operand B comes from Rd2.
    task automatic run_alu(input string tag, input logic [4:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] pc,
                           input logic [15:0] exp);
        idle_inputs();
        ALUOp_IDEX = op; Rd1_IDEX = a; Rd2_IDEX = b; PC2_IDEX = pc;
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd1;
        #1;
        check({tag, "_err"}, 16'(err), 16'h0000);
        step();
        check(tag, ALURes_EXMEM, exp);
    endtask

    task automatic run_branch(input string tag, input logic br, input logic [1:0] f,
                              input logic [15:0] rd1, input logic exp);
        idle_inputs();
        Branch_IDEX = br; ALUF_IDEX = f; Rd1_IDEX = rd1;
        step();
        check(tag, 16'(takeBranch_EXMEM), 16'(exp));
    endtask

    initial begin
        // Reset holds outputs at zero even with busy inputs and a clock edge.
        idle_inputs();
        rst = 1'b1;
        RegWrite_IDEX = 1'b1; halt_IDEX = 1'b1; Rd1_IDEX = 16'h1234;
        Rd2_IDEX = 16'h5678; PC2_IDEX = 16'h0100; WrR_IDEX = 3'd7;
        #2;
        check_all_zero("rst_init");
        step();
        check_all_zero("rst_edge");
        rst = 1'b0;

        // Overflowing add with immediate operand.
        idle_inputs();
        Rd1_IDEX = 16'h7FFF; Imm_IDEX = 16'h0001; Rd2_IDEX = 16'hABCD;
        ALUSrc_IDEX = 1'b1; RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd3; MemtoReg_IDEX = 1'b1;
        step();
        check("add_ovf", ALURes_EXMEM, 16'h8000);
        check("add_regwr", 16'(RegWrite_EXMEM), 16'h0001);
        check("add_wrr", 16'(WrR_EXMEM), 16'h0003);
        check("add_wrdata", WrData_EXMEM, 16'hABCD);
        check("add_m2r", 16'(MemtoReg_EXMEM), 16'h0001);

        // ALU operation table.
        run_alu("op_add",  5'h00, 16'h0005, 16'h0003, 16'h0000, 16'h0008);
        run_alu("op_sub",  5'h01, 16'h0005, 16'h0003, 16'h0000, 16'hFFFE);
        run_alu("op_sub2", 5'h01, 16'h0003, 16'h0005, 16'h0000, 16'h0002);
        run_alu("op_and",  5'h02, 16'h0005, 16'h0003, 16'h0000, 16'h0001);
        run_alu("op_or",   5'h03, 16'h0005, 16'h0003, 16'h0000, 16'h0007);
        run_alu("op_xor",  5'h04, 16'h0005, 16'h0003, 16'h0000, 16'h0006);
        run_alu("op_shl",  5'h05, 16'h0005, 16'h0003, 16'h0000, 16'h0028);
        run_alu("op_shl4", 5'h05, 16'h0001, 16'h0013, 16'h0000, 16'h0008);
        run_alu("op_shr",  5'h06, 16'hF001, 16'h0004, 16'h0000, 16'h0F00);
        run_alu("op_rol",  5'h07, 16'hF001, 16'h0004, 16'h0000, 16'h001F);
        run_alu("op_rol0", 5'h07, 16'hA5C3, 16'h0010, 16'h0000, 16'hA5C3);
        run_alu("op_passb",5'h08, 16'h0005, 16'h0003, 16'h0000, 16'h0003);
        run_alu("op_eq0",  5'h09, 16'h0005, 16'h0003, 16'h0000, 16'h0000);
        run_alu("op_eq1",  5'h09, 16'h00AA, 16'h00AA, 16'h0000, 16'h0001);
        run_alu("op_lt0",  5'h0A, 16'h0005, 16'h0003, 16'h0000, 16'h0000);
        run_alu("op_lt1",  5'h0A, 16'h8000, 16'h0001, 16'h0000, 16'h0001);
        run_alu("op_lts",  5'h0A, 16'h0001, 16'h8000, 16'h0000, 16'h0000);
        run_alu("op_le1",  5'h0B, 16'h0003, 16'h0003, 16'h0000, 16'h0001);
        run_alu("op_le0",  5'h0B, 16'h0005, 16'h0003, 16'h0000, 16'h0000);
        run_alu("op_cy1",  5'h0C, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001);
        run_alu("op_cy0",  5'h0C, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000);
        run_alu("op_link", 5'h0D, 16'h0005, 16'h0003, 16'h1234, 16'h1234);

        // Taken branch, then a squashed (also branching) store.
        idle_inputs();
        Branch_IDEX = 1'b1; Rd1_IDEX = 16'h0000; PC2_IDEX = 16'h0010; Imm_IDEX = 16'hFFFC;
        step();
        check("br_take", 16'(takeBranch_EXMEM), 16'h0001);
        check("br_tgt", BrTarget_EXMEM, 16'h000C);
        MemWrite_IDEX = 1'b1; MemRead_IDEX = 1'b1; RegWrite_IDEX = 1'b1; Dump_IDEX = 1'b1;
        ALUSrc_IDEX = 1'b1;
        step();
        check("sq_take", 16'(takeBranch_EXMEM), 16'h0000);
        check("sq_memwr", 16'(MemWrite_EXMEM), 16'h0000);
        check("sq_en", 16'({RegWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM}), 16'h0000);
        check("sq_data", ALURes_EXMEM, 16'hFFFC);
        // Same instruction again is no longer squashed.
        step();
        check("br_take2", 16'(takeBranch_EXMEM), 16'h0001);
        check("br_en2", 16'({RegWrite_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM}), 16'h000F);
        // Wrong-path halt is ignored.
        idle_inputs();
        halt_IDEX = 1'b1;
        step();
        check("sq_halt", 16'(halt_EXMEM), 16'h0000);
        check("sq_take3", 16'(takeBranch_EXMEM), 16'h0000);

        // Branch conditions.
        run_branch("bc_lt_t",  1'b1, 2'b10, 16'h8000, 1'b1);
        run_branch("bc_gap1",  1'b0, 2'b10, 16'h8000, 1'b0);
        run_branch("bc_ge_n",  1'b1, 2'b11, 16'h8000, 1'b0);
        run_branch("bc_ge_t",  1'b1, 2'b11, 16'h0000, 1'b1);
        run_branch("bc_gap2",  1'b0, 2'b00, 16'h0000, 1'b0);
        run_branch("bc_ne_n",  1'b1, 2'b01, 16'h0000, 1'b0);
        run_branch("bc_ne_t",  1'b1, 2'b01, 16'h0005, 1'b1);
        run_branch("bc_nobr",  1'b0, 2'b00, 16'h0000, 1'b0);
        run_branch("bc_eq_n",  1'b1, 2'b00, 16'h0005, 1'b0);

        // err on unassigned opcodes.
        idle_inputs();
        ALUOp_IDEX = 5'h1F; RegWrite_IDEX = 1'b1; Rd1_IDEX = 16'h0003; Rd2_IDEX = 16'h0004;
        #1;
        check("err_set", 16'(err), 16'h0001);
        step();
        check("err_res", ALURes_EXMEM, 16'h0000);
        check("err_regwr", 16'(RegWrite_EXMEM), 16'h0001);
        RegWrite_IDEX = 1'b0;
        #1;
        check("err_noen", 16'(err), 16'h0000);
        ALUOp_IDEX = 5'h0E; MemRead_IDEX = 1'b1;
        #1;
        check("err_0e", 16'(err), 16'h0001);
        ALUOp_IDEX = 5'h0D; MemRead_IDEX = 1'b0; MemWrite_IDEX = 1'b1;
        #1;
        check("err_0d", 16'(err), 16'h0000);

        // Sticky halt blocks later enables and branches.
        idle_inputs();
        halt_IDEX = 1'b1;
        step();
        check("halt_set", 16'(halt_EXMEM), 16'h0001);
        idle_inputs();
        RegWrite_IDEX = 1'b1; MemWrite_IDEX = 1'b1; MemRead_IDEX = 1'b1; Dump_IDEX = 1'b1;
        Branch_IDEX = 1'b1; Rd2_IDEX = 16'h0042; ALUOp_IDEX = 5'h08;
        step();
        check("halt_hold", 16'(halt_EXMEM), 16'h0001);
        check("halt_regwr", 16'(RegWrite_EXMEM), 16'h0000);
        check("halt_en", 16'({MemWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM, takeBranch_EXMEM}), 16'h0000);
        check("halt_data", ALURes_EXMEM, 16'h0042);
        step();
        check("halt_hold2", 16'(halt_EXMEM), 16'h0001);

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        #2 rst = 1'b0;
        idle_inputs();
        RegWrite_IDEX = 1'b1; WrR_IDEX = 3'd5; Rd1_IDEX = 16'h0001; Rd2_IDEX = 16'h0001;
        step();
        check("post_rst_regwr", 16'(RegWrite_EXMEM), 16'h0001);
        check("post_rst_wrr", 16'(WrR_EXMEM), 16'h0005);
        check("post_rst_res", ALURes_EXMEM, 16'h0002);
        check("post_rst_halt", 16'(halt_EXMEM), 16'h0000);

        // Reset drops a pending taken branch; the next branch is not squashed.
        idle_inputs();
        Branch_IDEX = 1'b1;
        step();
        check("pend_take", 16'(takeBranch_EXMEM), 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("pend_drop", 16'(takeBranch_EXMEM), 16'h0000);
        #2 rst = 1'b0;
        step();
        check("pend_reload", 16'(takeBranch_EXMEM), 16'h0001);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
